// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for one decoded 8051 arithmetic/logic
// instruction. Fetches the source operand from IRAM (immediate, direct, Rn or
// @Ri), drives the shared ALU for one cycle, then writes ACC and PSW.
// Optional feature: define ALU_SEQ_PARITY_EN to write PSW on every WB with
// bit 0 carrying the parity of the new accumulator value.
module alu_sequencer #(
    parameter logic [7:0] NOP_OPCODE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_opcode,
    input  logic [7:0] req_operand,
    input  logic [7:0] acc_in,
    input  logic [7:0] psw_in,
    output logic       mem_rd_en,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       alu_en,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    input  logic [8:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_ac,
    input  logic       alu_ov,
    output logic       acc_wr_en,
    output logic [7:0] acc_wr_data,
    output logic       psw_wr_en,
    output logic [7:0] psw_wr_data,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_PTR, S_RD_OP, S_EXEC, S_WB, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        SRC_IMM, SRC_DIR, SRC_IND, SRC_REG, SRC_BAD
    } src_t;

    // Classify an opcode by its addressing mode; unsupported opcodes map to SRC_BAD.
    function automatic src_t decode_src(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = op[7:4];
        lo = op[3:0];
        if (op == 8'h74) return SRC_IMM;
        if (!(hi inside {4'h2, 4'h9, 4'h5, 4'h4, 4'h6, 4'hE})) return SRC_BAD;
        if (lo == 4'h4) return (hi == 4'hE) ? SRC_BAD : SRC_IMM;
        if (lo == 4'h5) return SRC_DIR;
        if (lo == 4'h6 || lo == 4'h7) return SRC_IND;
        if (lo[3]) return SRC_REG;
        return SRC_BAD;
    endfunction

    state_t     state_q, state_d;
    src_t       src_q;
    src_t       req_src;
    logic [7:0] op_q;
    logic [7:0] operand_q;
    logic [7:0] acc_q;
    logic [1:0] bank_q;
    logic       is_arith;
    logic [7:0] flags_psw;
    logic       unused_inputs;

    assign req_src   = decode_src(req_opcode);
    assign is_arith  = (op_q[7:4] == 4'h2) || (op_q[7:4] == 4'h9);
    assign flags_psw = {alu_c, alu_ac, psw_in[5:3], alu_ov, psw_in[1:0]};
    // The carry copy in alu_result[8] and the overwritten PSW flag bits are not needed.
    assign unused_inputs = ^{alu_result[8], psw_in[7:6], psw_in[2]};

    // State register and capture of the accepted instruction context.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= S_IDLE;
            // NOTE: the capture registers are reset as well so no X can reach the
            // ALU or IRAM address bus after power-up; they are few and cheap.
            src_q     <= SRC_BAD;
            op_q      <= 8'h00;
            operand_q <= 8'h00;
            acc_q     <= 8'h00;
            bank_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                src_q     <= req_src;
                op_q      <= req_opcode;
                operand_q <= req_operand;
                acc_q     <= acc_in;
                bank_q    <= psw_in[4:3];
            end
        end
    end

    // Next-state decode and Moore outputs for each sequencing step.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a signal unassigned and infers a latch.
        state_d     = state_q;
        req_ready   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = 8'h00;
        alu_en      = 1'b0;
        alu_opcode  = NOP_OPCODE;
        alu_op1     = 8'h00;
        alu_op2     = 8'h00;
        acc_wr_en   = 1'b0;
        acc_wr_data = 8'h00;
        psw_wr_en   = 1'b0;
        psw_wr_data = 8'h00;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_src)
                        SRC_IMM:          state_d = S_EXEC;
                        SRC_DIR, SRC_REG: state_d = S_RD_OP;
                        SRC_IND:          state_d = S_RD_PTR;
                        default:          state_d = S_ERR;
                    endcase
                end
            end
            S_RD_PTR: begin
                mem_rd_en = 1'b1;
                mem_addr  = {3'b000, bank_q, 2'b00, op_q[0]};
                state_d   = S_RD_OP;
            end
            S_RD_OP: begin
                mem_rd_en = 1'b1;
                case (src_q)
                    SRC_IND: mem_addr = mem_rd_data;
                    SRC_DIR: mem_addr = operand_q;
                    default: mem_addr = {3'b000, bank_q, op_q[2:0]};
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                alu_en     = 1'b1;
                alu_opcode = op_q;
                alu_op1    = acc_q;
                alu_op2    = (src_q == SRC_IMM) ? operand_q : mem_rd_data;
                state_d    = S_WB;
            end
            S_WB: begin
                acc_wr_en   = 1'b1;
                acc_wr_data = alu_result[7:0];
                done        = 1'b1;
`ifdef ALU_SEQ_PARITY_EN
                psw_wr_en      = 1'b1;
                psw_wr_data    = is_arith ? flags_psw : psw_in;
                psw_wr_data[0] = ^alu_result[7:0];
`else
                psw_wr_en   = is_arith;
                psw_wr_data = is_arith ? flags_psw : 8'h00;
`endif
                state_d = S_IDLE;
            end
            S_ERR: begin
                done    = 1'b1;
                err     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with a registered IRAM model and a
// small stand-in for the shared ALU (result registered one cycle after alu_en).
module tb_alu_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_opcode;
    logic [7:0] req_operand;
    logic [7:0] acc_in;
    logic [7:0] psw_in;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       alu_en;
    logic [7:0] alu_opcode;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [8:0] alu_result = 9'h000;
    logic       alu_c = 1'b0;
    logic       alu_ac = 1'b0;
    logic       alu_ov = 1'b0;
    logic       acc_wr_en;
    logic [7:0] acc_wr_data;
    logic       psw_wr_en;
    logic [7:0] psw_wr_data;
    logic       done;
    logic       err;

    logic [7:0] iram [256];
    int checks = 0;
    int errors = 0;

    alu_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_operand(req_operand),
        .acc_in(acc_in), .psw_in(psw_in),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_c(alu_c), .alu_ac(alu_ac), .alu_ov(alu_ov),
        .acc_wr_en(acc_wr_en), .acc_wr_data(acc_wr_data),
        .psw_wr_en(psw_wr_en), .psw_wr_data(psw_wr_data),
        .done(done), .err(err)
    );

    always #5 clock = ~clock;

    // IRAM read port: data valid the cycle after the strobe.
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= iram[mem_addr];

    // ALU stand-in: registered result and flags.
    always @(posedge clock) begin
        if (alu_en) begin
            logic [8:0] r;
            logic [4:0] n;
            r = {1'b0, alu_op2};
            n = 5'h00;
            case (alu_opcode[7:4])
                4'h2: begin
                    r = {1'b0, alu_op1} + {1'b0, alu_op2};
                    n = {1'b0, alu_op1[3:0]} + {1'b0, alu_op2[3:0]};
                end
                4'h9: begin
                    r = {1'b0, alu_op1} - {1'b0, alu_op2} - {8'h00, psw_in[7]};
                    n = {1'b0, alu_op1[3:0]} - {1'b0, alu_op2[3:0]} - {4'h0, psw_in[7]};
                end
                4'h5: r = {1'b0, alu_op1 & alu_op2};
                4'h4: r = {1'b0, alu_op1 | alu_op2};
                4'h6: r = {1'b0, alu_op1 ^ alu_op2};
                default: r = {1'b0, alu_op2};
            endcase
            alu_result <= r;
            alu_c      <= r[8];
            alu_ac     <= n[4];
            alu_ov     <= (alu_opcode[7:4] == 4'h2) ? ((alu_op1[7] == alu_op2[7]) && (r[7] != alu_op1[7])) :
                          (alu_opcode[7:4] == 4'h9) ? ((alu_op1[7] != alu_op2[7]) && (r[7] != alu_op1[7])) : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [7:0] op, input logic [7:0] opnd,
                           input logic [7:0] acc, input logic [7:0] psw);
        req_valid   = 1'b1;
        req_opcode  = op;
        req_operand = opnd;
        acc_in      = acc;
        psw_in      = psw;
    endtask

    initial begin
        int seen;
        foreach (iram[i]) iram[i] = 8'h00;
        iram[8'h30] = 8'h0F;
        iram[8'h11] = 8'h40;
        iram[8'h40] = 8'hA5;
        iram[8'h1F] = 8'h05;
        iram[8'h13] = 8'h22;
        reset = 1'b1;
        req_valid = 1'b0; req_opcode = 8'h00; req_operand = 8'h00;
        acc_in = 8'h00; psw_in = 8'h00;
        tick(); tick();
        reset = 1'b0;

        // Reset state.
        check("reset_ctl", {9'h0, req_ready, mem_rd_en, alu_en, acc_wr_en, psw_wr_en, done, err},
              {9'h0, 7'b1000000});
        check("reset_data", {alu_opcode, mem_addr}, 16'h0000);
        check("reset_wdata", {acc_wr_data, psw_wr_data}, 16'h0000);

        // ADD A,#01 with ACC=FF: 2-cycle latency, carry set, ACC snapshot held.
        request(8'h24, 8'h01, 8'hFF, 8'h00);
        tick();
        req_valid = 1'b0; acc_in = 8'h00;
        check("add_exec", {req_ready, alu_en, done, 5'b0, alu_opcode}, {8'b01000000, 8'h24});
        check("add_ops", {alu_op1, alu_op2}, 16'hFF01);
        tick();
        check("add_wb", {acc_wr_en, psw_wr_en, done, err, 4'b0, acc_wr_data}, {8'b11100000, 8'h00});
        check("add_psw", {8'h00, psw_wr_data}, 16'h00C0);
        tick();
        check("add_idle", {req_ready, done, 6'b0, alu_opcode}, {8'b10000000, 8'h00});

        // ANL A,30h with IRAM[30]=0F, ACC=3C.
        request(8'h55, 8'h30, 8'h3C, 8'h00);
        tick();
        req_valid = 1'b0;
        check("anl_rd", {mem_rd_en, 7'b0, mem_addr}, {8'b10000000, 8'h30});
        tick();
        check("anl_exec", {alu_op1, alu_op2}, 16'h3C0F);
        tick();
        check("anl_wb", {done, acc_wr_en, 6'b0, acc_wr_data}, {8'b11000000, 8'h0C});
`ifdef ALU_SEQ_PARITY_EN
        check("anl_psw", {7'b0, psw_wr_en, psw_wr_data}, {7'b0, 1'b1, 8'h00});
`else
        check("anl_psw", {15'b0, psw_wr_en}, 16'h0000);
`endif
        tick();

        // MOV A,@R1 in bank 2: reads 11h then 40h, 4-cycle latency.
        request(8'hE7, 8'h00, 8'h00, 8'h10);
        tick();
        req_valid = 1'b0;
        check("ind_ptr", {mem_rd_en, 7'b0, mem_addr}, {8'b10000000, 8'h11});
        tick();
        check("ind_op", {mem_rd_en, 7'b0, mem_addr}, {8'b10000000, 8'h40});
        tick();
        check("ind_exec", {alu_en, done, 6'b0, alu_op2}, {8'b10000000, 8'hA5});
        tick();
        check("ind_wb", {done, acc_wr_en, 6'b0, acc_wr_data}, {8'b11000000, 8'hA5});
`ifdef ALU_SEQ_PARITY_EN
        check("ind_psw", {7'b0, psw_wr_en, psw_wr_data}, {7'b0, 1'b1, 8'h10});
`else
        check("ind_psw", {15'b0, psw_wr_en}, 16'h0000);
`endif
        tick();

        // ADD A,R7 in bank 3: address 1Fh, 10h+05h=15h.
        request(8'h2F, 8'h00, 8'h10, 8'h18);
        tick();
        req_valid = 1'b0;
        check("r7_addr", {8'h00, mem_addr}, 16'h001F);
        tick(); tick();
        check("r7_wb", {done, psw_wr_en, 6'b0, acc_wr_data}, {8'b11000000, 8'h15});
`ifdef ALU_SEQ_PARITY_EN
        check("r7_psw", {8'h00, psw_wr_data}, 16'h0019);
`else
        check("r7_psw", {8'h00, psw_wr_data}, 16'h0018);
`endif
        tick();
        psw_in = 8'h00;

        // Unsupported opcode 00h: done+err after 1 cycle, no writes or ALU pulse.
        request(8'h00, 8'h00, 8'h00, 8'h00);
        check("bad_idle_alu", {15'b0, alu_en}, 16'h0000);
        tick();
        req_valid = 1'b0;
        check("bad_err", {9'b0, done, err, acc_wr_en, psw_wr_en, alu_en, req_ready, mem_rd_en},
              {9'b0, 7'b1100000});
        tick();
        check("bad_idle", {15'b0, req_ready}, 16'h0001);

        // Reset in RD_OP of SUBB A,R3 aborts without writes.
        request(8'h9B, 8'h00, 8'h50, 8'h00);
        tick();
        req_valid = 1'b0;
        check("subb_rdop", {mem_rd_en, 7'b0, mem_addr}, {8'b10000000, 8'h03});
        reset = 1'b1;
        tick();
        check("abort_idle", {12'b0, req_ready, acc_wr_en, psw_wr_en, done}, 16'h0008);
        // Reset coincident with a request: not accepted.
        request(8'h24, 8'h01, 8'h01, 8'h00);
        tick();
        check("rst_wins", {14'b0, req_ready, alu_en}, 16'h0002);
        reset = 1'b0;
        req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (acc_wr_en || psw_wr_en || done || alu_en) seen++;
            tick();
        end
        check("abort_quiet", seen[15:0], 16'h0000);

        // Back-to-back: req_valid held, second accept only after first done.
        request(8'h74, 8'h5A, 8'h00, 8'h00);
        tick();
        check("b2b_exec1", {7'b0, req_ready, alu_opcode}, {8'h00, 8'h74});
        tick();
        check("b2b_wb1", {done, req_ready, 6'b0, alu_opcode}, {8'b10000000, 8'h00});
        check("b2b_data1", {8'h00, acc_wr_data}, 16'h005A);
        tick();
        check("b2b_idle", {7'b0, req_ready, alu_opcode}, {8'h01, 8'h00});
        tick();
        req_valid = 1'b0;
        check("b2b_exec2", {7'b0, req_ready, alu_opcode}, {8'h00, 8'h74});
        tick();
        check("b2b_wb2", {15'b0, done}, 16'h0001);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
